// File: rtl/gemac_regs_pkg.sv
// Shared GEMAC register map, MII command/status bit positions and the
// bring-up sequencer state type.
package gemac_regs_pkg;

    // Register indices; the byte address on the bus is index << 2.
    localparam logic [3:0] REG_MISC     = 4'd0;
    localparam logic [3:0] REG_UCAST_H  = 4'd1;
    localparam logic [3:0] REG_UCAST_L  = 4'd2;
    localparam logic [3:0] REG_MIIMODER = 4'd5;
    localparam logic [3:0] REG_MIIADDR  = 4'd6;
    localparam logic [3:0] REG_MIICMD   = 4'd8;
    localparam logic [3:0] REG_MIISTAT  = 4'd9;
    localparam logic [3:0] REG_MIIRX    = 4'd10;

    // MIICOMMAND bits
    localparam int CMD_WCTRL = 2;
    localparam int CMD_RSTAT = 1;
    localparam int CMD_SCAN  = 0;

    // MIISTATUS bits
    localparam int STAT_NVALID   = 2;
    localparam int STAT_BUSY     = 1;
    localparam int STAT_LINKFAIL = 0;

    // Sequencer states; S_WRITE is qualified by a separate table index.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_POLL_A = 3'd2,
        S_POLL_B = 3'd3,
        S_FETCH  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    function automatic logic [7:0] reg_adr(input logic [3:0] idx);
        return {2'b00, idx, 2'b00};
    endfunction

endpackage

// File: rtl/wb_master_port.sv
// Single-access Wishbone engine: launches one access per request, drops the
// strobe at the ack edge (so there is always an idle cycle before the next
// access) and aborts the access when the ack watchdog expires.
module wb_master_port #(
    parameter logic [3:0] ACK_TIMEOUT = 4'd15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [7:0]  i_adr,
    input  logic [31:0] i_dat,
    output logic        o_cyc,
    output logic        o_stb,
    output logic        o_we,
    output logic [7:0]  o_adr,
    output logic [31:0] o_dat,
    input  logic        i_ack,
    input  logic [31:0] i_rdat,
    output logic        o_ack,
    output logic        o_timeout,
    output logic [31:0] o_rdat
);

    logic        r_cyc;
    logic        r_we;
    logic [7:0]  r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_wd;

    // Ack only counts while our own cycle is open; read data is gated by it.
    assign o_ack     = r_cyc & i_ack;
    assign o_timeout = r_cyc & ~i_ack & (r_wd == ACK_TIMEOUT);
    assign o_rdat    = o_ack ? i_rdat : 32'h0;

    assign o_cyc = r_cyc;
    assign o_stb = r_cyc;
    assign o_we  = r_we;
    assign o_adr = r_adr;
    assign o_dat = r_dat;

    // Access register: address/data/we are loaded only at launch, so they
    // stay stable for the whole cycle; the watchdog restarts at each launch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= 8'h0;
            r_dat <= 32'h0;
            r_wd  <= 4'h0;
        end else if (r_cyc) begin
            if (o_ack || o_timeout) begin
                r_cyc <= 1'b0;
            end else begin
                r_wd <= r_wd + 4'd1;
            end
        end else if (i_req) begin
            r_cyc <= 1'b1;
            r_we  <= i_we;
            r_adr <= i_adr;
            r_dat <= i_dat;
            r_wd  <= 4'h0;
        end
    end

endmodule

// File: rtl/gemac_wb_init_master.sv
// GEMAC bring-up initiator: writes MAC settings, station address, MDC
// divider and PHY address, runs one MDIO read and returns the PHY data.
module gemac_wb_init_master
    import gemac_regs_pkg::*;
#(
    parameter logic [6:0]  MISC_SETTINGS = 7'b0111101,
    parameter logic [47:0] UCAST_ADDR    = 48'hA0B0_C0D0_E0F0,
    parameter logic [7:0]  MII_DIVIDER   = 8'd20,
    parameter logic        NO_PRE        = 1'b0,
    parameter logic [4:0]  PHY_ADDR      = 5'd0,
    parameter logic [4:0]  PHY_REG       = 5'd1,
    parameter logic [15:0] POLL_LIMIT    = 16'd4096,
    parameter logic [3:0]  ACK_TIMEOUT   = 4'd15
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        start,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [7:0]  wb_adr,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] phy_data,
    output logic        link_up,
    output state_t      dbg_state
);

    state_t      r_state, w_next;
    logic [2:0]  r_idx, w_idx_next;
    logic [15:0] r_cnt, w_cnt_next;
    logic [15:0] r_phy;
    logic        r_link;

    logic        w_req, w_req_we, w_cap;
    logic [7:0]  w_req_adr;
    logic [31:0] w_req_dat;
    logic        w_ack, w_timeout;
    logic [31:0] w_rdat;
    logic        w_unused_rdat;

    assign w_unused_rdat = ^w_rdat[31:16];

    function automatic logic [7:0] wr_adr(input logic [2:0] i);
        case (i)
            3'd0:    return reg_adr(REG_MISC);
            3'd1:    return reg_adr(REG_UCAST_H);
            3'd2:    return reg_adr(REG_UCAST_L);
            3'd3:    return reg_adr(REG_MIIMODER);
            3'd4:    return reg_adr(REG_MIIADDR);
            default: return reg_adr(REG_MIICMD);
        endcase
    endfunction

    function automatic logic [31:0] wr_dat(input logic [2:0] i);
        case (i)
            3'd0:    return {25'b0, MISC_SETTINGS};
            3'd1:    return {16'b0, UCAST_ADDR[47:32]};
            3'd2:    return UCAST_ADDR[31:0];
            3'd3:    return {23'b0, NO_PRE, MII_DIVIDER};
            3'd4:    return {19'b0, PHY_REG, 3'b0, PHY_ADDR};
            default: return 32'h1 << CMD_RSTAT;
        endcase
    endfunction

    wb_master_port #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_port (
        .i_clk     (wb_clk),
        .i_rst     (wb_rst),
        .i_req     (w_req),
        .i_we      (w_req_we),
        .i_adr     (w_req_adr),
        .i_dat     (w_req_dat),
        .o_cyc     (wb_cyc),
        .o_stb     (wb_stb),
        .o_we      (wb_we),
        .o_adr     (wb_adr),
        .o_dat     (wb_dat_o),
        .i_ack     (wb_ack),
        .i_rdat    (wb_dat_i),
        .o_ack     (w_ack),
        .o_timeout (w_timeout),
        .o_rdat    (w_rdat)
    );

    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_ERR);
    assign phy_data  = r_phy;
    assign link_up   = r_link;
    assign dbg_state = r_state;

    // Sequencer state, write index, poll counter and PHY result registers.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
            r_cnt   <= 16'd0;
            r_phy   <= 16'h0;
            r_link  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            if (w_cap) begin
                r_phy  <= w_rdat[15:0];
                r_link <= w_rdat[2];
            end
        end
    end

    // Next state and access request; an access state re-requests whenever
    // the engine is idle, which yields exactly one idle cycle per access.
    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        w_cnt_next = r_cnt;
        w_cap      = 1'b0;
        w_req      = 1'b0;
        w_req_we   = 1'b0;
        w_req_adr  = 8'h0;
        w_req_dat  = 32'h0;
        case (r_state)
            S_WRITE: begin
                w_req     = ~wb_cyc;
                w_req_we  = 1'b1;
                w_req_adr = wr_adr(r_idx);
                w_req_dat = wr_dat(r_idx);
                if (w_timeout) begin
                    w_next = S_ERR;
                end else if (w_ack) begin
                    if (r_idx == 3'd5) begin
                        w_next = S_POLL_A;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end
            end
            S_POLL_A, S_POLL_B: begin
                w_req     = ~wb_cyc;
                w_req_adr = reg_adr(REG_MIISTAT);
                if (w_timeout) begin
                    w_next = S_ERR;
                end else if (w_ack) begin
                    w_cnt_next = r_cnt + 16'd1;
                    if (r_state == S_POLL_B && !w_rdat[STAT_BUSY]) begin
                        w_next = S_FETCH;
                    end else if ({1'b0, r_cnt} + 17'd1 >= {1'b0, POLL_LIMIT}) begin
                        w_next = S_ERR;
                    end else if (r_state == S_POLL_A && w_rdat[STAT_BUSY]) begin
                        w_next = S_POLL_B;
                    end
                end
            end
            S_FETCH: begin
                w_req     = ~wb_cyc;
                w_req_adr = reg_adr(REG_MIIRX);
                if (w_timeout) begin
                    w_next = S_ERR;
                end else if (w_ack) begin
                    w_cap  = 1'b1;
                    w_next = S_DONE;
                end
            end
            default: begin
                // IDLE, DONE, ERR: a start launches the first write at once.
                if (start) begin
                    w_next     = S_WRITE;
                    w_idx_next = 3'd0;
                    w_cnt_next = 16'd0;
                    w_req      = 1'b1;
                    w_req_we   = 1'b1;
                    w_req_adr  = wr_adr(3'd0);
                    w_req_dat  = wr_dat(3'd0);
                end
            end
        endcase
    end

endmodule
